// File: rtl/cache_mshr_file_if.sv
// Request, memory-issue and fill channels of the MSHR file, plus its occupancy status.
interface cache_mshr_file_if #(
  parameter int ENTRIES = 4,
  parameter int ADDR_W  = 32,
  parameter int WORDS   = 4,
  parameter int UUID_W  = 8
);
  localparam int ID_W = $clog2(ENTRIES);

  logic                  miss_valid;
  logic                  miss_ready;
  logic [ADDR_W-1:0]     miss_addr;
  logic                  miss_write;
  logic [31:0]           miss_wdata;
  logic [UUID_W-1:0]     miss_uuid;
  logic                  miss_merged;

  logic                  issue_valid;
  logic                  issue_ready;
  logic [ID_W-1:0]       issue_id;
  logic [ADDR_W-1:0]     issue_block_addr;

  logic                  fill_valid;
  logic [ID_W-1:0]       fill_id;
  logic [ADDR_W-1:0]     fill_block_addr;
  logic [WORDS-1:0]      fill_wmask;
  logic [WORDS*32-1:0]   fill_wdata;
  logic [UUID_W-1:0]     fill_uuid;
  logic                  spurious_fill;

  logic [ID_W:0]         occupancy;
  logic                  empty;
  logic                  full;

  modport slave (
    input  miss_valid, miss_addr, miss_write, miss_wdata, issue_ready, fill_valid, fill_id,
    output miss_ready, miss_uuid, miss_merged, issue_valid, issue_id, issue_block_addr,
           fill_block_addr, fill_wmask, fill_wdata, fill_uuid, spurious_fill,
           occupancy, empty, full
  );

  modport master (
    output miss_valid, miss_addr, miss_write, miss_wdata, issue_ready, fill_valid, fill_id,
    input  miss_ready, miss_uuid, miss_merged, issue_valid, issue_id, issue_block_addr,
           fill_block_addr, fill_wmask, fill_wdata, fill_uuid, spurious_fill,
           occupancy, empty, full
  );
endinterface

// File: rtl/cache_mshr_file.sv
// MSHR file for one cache bank: coalesces misses per block, issues primaries in
// allocation order and retires entries on out-of-order fills with the merged store data.
module cache_mshr_file #(
  parameter int ENTRIES   = 4,
  parameter int ADDR_W    = 32,
  parameter int WORDS     = 4,
  parameter int UUID_W    = 8,
  parameter int MAX_MERGE = 4
) (
  input logic              CLK,
  input logic              RST,
  cache_mshr_file_if.slave bus
);
  localparam int ID_W   = $clog2(ENTRIES);
  localparam int WIDX_W = $clog2(WORDS);
  localparam int OFF_W  = WIDX_W + 2;
  localparam int CNT_W  = $clog2(MAX_MERGE + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_MERGE);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(WORDS * 4 - 1);

  typedef enum logic [1:0] {FREE, WAIT, ISSUED} ent_state_t;

  ent_state_t           st     [ENTRIES];
  ent_state_t           st_nxt [ENTRIES];
  logic [ADDR_W-1:0]    blk    [ENTRIES];
  logic [WORDS-1:0]     wmask  [ENTRIES];
  logic [WORDS*32-1:0]  wdata  [ENTRIES];
  logic [UUID_W-1:0]    uuid   [ENTRIES];
  logic [CNT_W-1:0]     mcnt   [ENTRIES];
  logic [ID_W-1:0]      fifo_mem [ENTRIES];
  logic [ID_W:0]        wr_ptr, rd_ptr;
  logic [UUID_W-1:0]    tag;

  logic [ADDR_W-1:0]    req_blk;
  logic [WIDX_W-1:0]    widx;
  logic                 hit, any_free, ready, accept, alloc, merge, issue_fire, fill_retire;
  logic [ID_W-1:0]      hit_idx, free_idx, head_id;
  logic [ID_W:0]        occ;

  assign req_blk = bus.miss_addr & BLK_MASK;
  assign widx    = bus.miss_addr[OFF_W-1:2];

  // Descending scan so the lowest free index wins; at most one busy entry can match.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    any_free = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (st[i] == FREE) begin
        any_free = 1'b1;
        free_idx = ID_W'(i);
      end else if (blk[i] == req_blk) begin
        hit     = 1'b1;
        hit_idx = ID_W'(i);
      end
    end
  end

  // Next-state: issue and retire always target entries in WAIT/ISSUED, never a FREE one.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      st_nxt[i] = st[i];
      if (alloc && free_idx == ID_W'(i))               st_nxt[i] = WAIT;
      if (issue_fire && head_id == ID_W'(i))           st_nxt[i] = ISSUED;
      if (fill_retire && bus.fill_id == ID_W'(i))      st_nxt[i] = FREE;
    end
  end

  // A matching entry being filled refuses the merge; the request reallocates next cycle.
  always_comb begin
    if (hit) ready = (mcnt[hit_idx] < MAX_CNT) && !(bus.fill_valid && bus.fill_id == hit_idx);
    else     ready = any_free;
    accept      = bus.miss_valid && ready && !RST;
    alloc       = accept && !hit;
    merge       = accept && hit;
    head_id     = fifo_mem[rd_ptr[ID_W-1:0]];
    issue_fire  = (wr_ptr != rd_ptr) && bus.issue_ready;
    fill_retire = bus.fill_valid && st[bus.fill_id] == ISSUED;

    bus.miss_ready       = ready;
    bus.miss_uuid        = accept ? tag : '0;
    bus.miss_merged      = merge;
    bus.issue_valid      = (wr_ptr != rd_ptr);
    bus.issue_id         = head_id;
    bus.issue_block_addr = blk[head_id];

    bus.fill_block_addr = '0;
    bus.fill_wmask      = '0;
    bus.fill_wdata      = '0;
    bus.fill_uuid       = '0;
    if (bus.fill_valid) begin
      bus.fill_block_addr = blk[bus.fill_id];
      bus.fill_wmask      = wmask[bus.fill_id];
      bus.fill_wdata      = wdata[bus.fill_id];
      bus.fill_uuid       = uuid[bus.fill_id];
    end
    bus.spurious_fill = bus.fill_valid && !RST && st[bus.fill_id] != ISSUED;

    occ = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (st[i] != FREE) occ = occ + 1'b1;
    end
    bus.occupancy = occ;
    bus.empty     = (occ == '0);
    bus.full      = (occ == (ID_W + 1)'(ENTRIES));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        st[i]       <= FREE;
        blk[i]      <= '0;
        wmask[i]    <= '0;
        wdata[i]    <= '0;
        uuid[i]     <= '0;
        mcnt[i]     <= '0;
        fifo_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      tag    <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) st[i] <= st_nxt[i];
      if (accept)     tag <= tag + 1'b1;
      if (issue_fire) rd_ptr <= rd_ptr + 1'b1;
      if (alloc) begin
        fifo_mem[wr_ptr[ID_W-1:0]] <= free_idx;
        wr_ptr                     <= wr_ptr + 1'b1;
        blk[free_idx]              <= req_blk;
        uuid[free_idx]             <= tag;
        mcnt[free_idx]             <= CNT_W'(1);
        for (int w = 0; w < WORDS; w++) begin
          wmask[free_idx][w]          <= bus.miss_write && widx == WIDX_W'(w);
          wdata[free_idx][32*w +: 32] <= (bus.miss_write && widx == WIDX_W'(w)) ? bus.miss_wdata : 32'd0;
        end
      end
      if (merge) begin
        mcnt[hit_idx] <= mcnt[hit_idx] + 1'b1;
        uuid[hit_idx] <= tag;
        if (bus.miss_write) begin
          wmask[hit_idx][widx]               <= 1'b1;
          wdata[hit_idx][{widx, 5'd0} +: 32] <= bus.miss_wdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_cache_mshr_file.sv
// Bench for cache_mshr_file: directed vector table, corner sequences and random traffic
// checked every cycle against a queue-based reference model.
module tb_cache_mshr_file;
  localparam int ENTRIES = 4, ADDR_W = 32, WORDS = 4, UUID_W = 8, MAX_MERGE = 4;
  localparam int ID_W = $clog2(ENTRIES);

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  cache_mshr_file_if #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .WORDS(WORDS), .UUID_W(UUID_W)) bus ();

  cache_mshr_file #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .WORDS(WORDS), .UUID_W(UUID_W),
                    .MAX_MERGE(MAX_MERGE)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: per-entry records plus an allocation-order issue queue.
  bit          m_busy   [ENTRIES];
  bit          m_issued [ENTRIES];
  logic [31:0] m_blk    [ENTRIES];
  logic [3:0]  m_mask   [ENTRIES];
  logic [31:0] m_data   [ENTRIES][WORDS];
  int          m_uuid   [ENTRIES];
  int          m_cnt    [ENTRIES];
  int          m_q[$];
  int          m_tag;

  logic       s_ready, s_merged, s_iv, s_spur, s_full;
  logic [7:0] s_uuid;
  logic [1:0] s_issue_id;
  logic [2:0] s_occ;
  logic [3:0] s_wmask;

  typedef struct {
    bit mv; logic [31:0] addr; bit wr; logic [31:0] wd; bit ir; bit fv; int fid;
    bit e_ready; int e_uuid; bit e_merged; bit e_iv; int e_occ; logic [3:0] e_wmask;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_busy[i] = 0; m_issued[i] = 0; m_cnt[i] = 0;
    end
    m_q.delete();
    m_tag = 0;
  endtask

  function automatic bit any_busy();
    for (int i = 0; i < ENTRIES; i++) if (m_busy[i]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive at edge+1, compare at the falling edge, commit the model after the edge.
  task automatic step(input bit mv, input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                      input bit ir, input bit fv, input int fid);
    logic [31:0]  blk;
    logic [127:0] exp_data;
    int w, match, ffree, nbusy, head;
    bit ready, acc, iv, spur, retire;
    bus.miss_valid = mv; bus.miss_addr = addr; bus.miss_write = wr; bus.miss_wdata = wd;
    bus.issue_ready = ir; bus.fill_valid = fv; bus.fill_id = ID_W'(fid);
    #4;
    blk = addr & ~32'(WORDS * 4 - 1);
    w = int'((addr >> 2) % WORDS);
    match = -1; ffree = -1; nbusy = 0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (m_busy[i]) begin
        nbusy++;
        if (m_blk[i] == blk) match = i;
      end else ffree = i;
    end
    if (match >= 0) ready = (m_cnt[match] < MAX_MERGE) && !(fv && fid == match);
    else            ready = (ffree >= 0);
    acc    = mv && ready;
    iv     = m_q.size() > 0;
    head   = iv ? m_q[0] : 0;
    spur   = fv && !(m_busy[fid] && m_issued[fid]);
    retire = fv && !spur;

    s_ready = bus.miss_ready; s_merged = bus.miss_merged; s_uuid = bus.miss_uuid;
    s_iv = bus.issue_valid; s_issue_id = bus.issue_id; s_spur = bus.spurious_fill;
    s_occ = bus.occupancy; s_full = bus.full; s_wmask = bus.fill_wmask;

    chk("miss_ready", 128'(s_ready), 128'(ready));
    chk("miss_uuid", 128'(s_uuid), 128'(acc ? m_tag : 0));
    chk("miss_merged", 128'(s_merged), 128'(acc && match >= 0));
    chk("issue_valid", 128'(s_iv), 128'(iv));
    if (iv) begin
      chk("issue_id", 128'(s_issue_id), 128'(head));
      chk("issue_block_addr", 128'(bus.issue_block_addr), 128'(m_blk[head]));
    end
    chk("spurious_fill", 128'(s_spur), 128'(spur));
    if (retire) begin
      exp_data = '0;
      for (int k = 0; k < WORDS; k++) exp_data[32*k +: 32] = m_data[fid][k];
      chk("fill_block_addr", 128'(bus.fill_block_addr), 128'(m_blk[fid]));
      chk("fill_wmask", 128'(s_wmask), 128'(m_mask[fid]));
      chk("fill_wdata", bus.fill_wdata, exp_data);
      chk("fill_uuid", 128'(bus.fill_uuid), 128'(m_uuid[fid]));
    end
    chk("occupancy", 128'(s_occ), 128'(nbusy));
    chk("empty", 128'(bus.empty), 128'(nbusy == 0));
    chk("full", 128'(s_full), 128'(nbusy == ENTRIES));

    @(posedge CLK);
    #1;
    if (retire) m_busy[fid] = 0;
    if (iv && ir) begin
      m_issued[head] = 1;
      void'(m_q.pop_front());
    end
    if (acc) begin
      if (match >= 0) begin
        m_cnt[match]++;
        m_uuid[match] = m_tag;
        if (wr) begin m_mask[match][w] = 1'b1; m_data[match][w] = wd; end
      end else begin
        m_busy[ffree] = 1; m_issued[ffree] = 0; m_blk[ffree] = blk;
        m_cnt[ffree] = 1; m_uuid[ffree] = m_tag; m_mask[ffree] = '0;
        for (int k = 0; k < WORDS; k++) m_data[ffree][k] = '0;
        if (wr) begin m_mask[ffree][w] = 1'b1; m_data[ffree][w] = wd; end
        m_q.push_back(ffree);
      end
      m_tag = (m_tag + 1) % (1 << UUID_W);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * ENTRIES + 4 && (m_q.size() > 0 || any_busy()); k++) begin
      if (m_q.size() > 0) step(0, 0, 0, 0, 1, 0, 0);
      else begin
        int j = 0;
        for (int i = ENTRIES - 1; i >= 0; i--) if (m_busy[i] && m_issued[i]) j = i;
        step(0, 0, 0, 0, 0, 1, j);
      end
    end
    chk("drain_empty", 128'(bus.empty), 128'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int fid;
    tbl[0] = '{1, 32'h1000, 0, 0,     0, 0, 0, 1, 0, 0, 0, 0, 4'b0000};
    tbl[1] = '{0, 0,        0, 0,     1, 0, 0, 1, 0, 0, 1, 1, 4'b0000};
    tbl[2] = '{0, 0,        0, 0,     0, 1, 0, 1, 0, 0, 0, 1, 4'b0000};
    tbl[3] = '{0, 0,        0, 0,     0, 0, 0, 1, 0, 0, 0, 0, 4'b0000};
    tbl[4] = '{1, 32'h2004, 1, 'hAA,  0, 0, 0, 1, 1, 0, 0, 0, 4'b0000};
    tbl[5] = '{1, 32'h200C, 1, 'hBB,  0, 0, 0, 1, 2, 1, 1, 1, 4'b0000};
    tbl[6] = '{1, 32'h2004, 1, 'hCC,  1, 0, 0, 1, 3, 1, 1, 1, 4'b0000};
    tbl[7] = '{0, 0,        0, 0,     0, 1, 0, 1, 0, 0, 0, 1, 4'b1010};
    tbl[8] = '{0, 0,        0, 0,     0, 0, 0, 1, 0, 0, 0, 0, 4'b0000};

    bus.miss_valid = 0; bus.miss_addr = 0; bus.miss_write = 0; bus.miss_wdata = 0;
    bus.issue_ready = 0; bus.fill_valid = 0; bus.fill_id = 0;
    model_reset();
    #2;
    chk("rst_occupancy", 128'(bus.occupancy), 128'(0));
    chk("rst_empty", 128'(bus.empty), 128'(1));
    chk("rst_full", 128'(bus.full), 128'(0));
    chk("rst_issue_valid", 128'(bus.issue_valid), 128'(0));
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].mv, tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].ir, tbl[i].fv, tbl[i].fid);
      chk($sformatf("vec%0d_ready", i), 128'(s_ready), 128'(tbl[i].e_ready));
      chk($sformatf("vec%0d_uuid", i), 128'(s_uuid), 128'(tbl[i].e_uuid));
      chk($sformatf("vec%0d_merged", i), 128'(s_merged), 128'(tbl[i].e_merged));
      chk($sformatf("vec%0d_issue_valid", i), 128'(s_iv), 128'(tbl[i].e_iv));
      chk($sformatf("vec%0d_occupancy", i), 128'(s_occ), 128'(tbl[i].e_occ));
      if (tbl[i].fv) chk($sformatf("vec%0d_fill_wmask", i), 128'(s_wmask), 128'(tbl[i].e_wmask));
    end

    // Merge limit, then a same-cycle fill of the saturated entry.
    step(1, 32'h3000, 0, 0, 0, 0, 0);
    step(1, 32'h3000, 0, 0, 1, 0, 0);
    step(1, 32'h3000, 0, 0, 0, 0, 0);
    step(1, 32'h3000, 0, 0, 0, 0, 0);
    step(1, 32'h3000, 0, 0, 0, 0, 0);
    chk("merge_limit_stall", 128'(s_ready), 128'(0));
    step(1, 32'h3000, 0, 0, 0, 1, 0);
    chk("merge_limit_fill_stall", 128'(s_ready), 128'(0));
    step(1, 32'h3000, 0, 0, 0, 0, 0);
    chk("merge_limit_realloc_ready", 128'(s_ready), 128'(1));
    chk("merge_limit_realloc_merged", 128'(s_merged), 128'(0));
    drain();

    // Full file, fill of id 2 frees the slot only for the next cycle.
    for (int b = 0; b < ENTRIES; b++) step(1, 32'h5000 + 32'(b * 16), 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("full_flag", 128'(s_full), 128'(1));
    step(1, 32'h6000, 0, 0, 0, 0, 0);
    chk("full_stall", 128'(s_ready), 128'(0));
    for (int b = 0; b < ENTRIES; b++) step(1, 32'h6000, 0, 0, 1, 0, 0);
    step(1, 32'h6000, 0, 0, 0, 1, 2);
    chk("full_fill_same_cycle", 128'(s_ready), 128'(0));
    step(1, 32'h6000, 0, 0, 0, 0, 0);
    chk("full_realloc_ready", 128'(s_ready), 128'(1));
    step(0, 0, 0, 0, 0, 0, 0);
    chk("full_realloc_id", 128'(s_issue_id), 128'(2));
    step(0, 0, 0, 0, 0, 1, 3);
    chk("ooo_fill3", 128'(s_spur), 128'(0));
    step(0, 0, 0, 0, 0, 1, 0);
    chk("ooo_fill0", 128'(s_spur), 128'(0));
    drain();

    // Miss colliding with the fill of its own block.
    step(1, 32'h4000, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 32'h4000, 0, 0, 0, 1, 0);
    chk("collide_stall", 128'(s_ready), 128'(0));
    step(1, 32'h4000, 0, 0, 0, 0, 0);
    chk("collide_alloc_ready", 128'(s_ready), 128'(1));
    chk("collide_alloc_merged", 128'(s_merged), 128'(0));
    drain();

    // Spurious fills to FREE and to WAIT entries.
    step(0, 0, 0, 0, 0, 1, 3);
    chk("spurious_free", 128'(s_spur), 128'(1));
    step(1, 32'h8000, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("spurious_wait", 128'(s_spur), 128'(1));
    chk("spurious_wait_occ", 128'(s_occ), 128'(1));
    drain();

    // Asynchronous reset mid-stream.
    step(1, 32'h9000, 0, 0, 0, 0, 0);
    step(1, 32'h9010, 0, 0, 1, 0, 0);
    bus.miss_valid = 1; bus.miss_addr = 32'h9000; bus.fill_valid = 1; bus.fill_id = 0;
    #2 RST = 1'b1;
    #1;
    chk("midrst_occupancy", 128'(bus.occupancy), 128'(0));
    chk("midrst_issue_valid", 128'(bus.issue_valid), 128'(0));
    chk("midrst_empty", 128'(bus.empty), 128'(1));
    chk("midrst_full", 128'(bus.full), 128'(0));
    chk("midrst_uuid", 128'(bus.miss_uuid), 128'(0));
    chk("midrst_merged", 128'(bus.miss_merged), 128'(0));
    chk("midrst_spurious", 128'(bus.spurious_fill), 128'(0));
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 0, 1, 0);
    chk("post_rst_fill_spurious", 128'(s_spur), 128'(1));

    // Tag wrap: the 257th accept after reset carries tag 0 again.
    for (int k = 0; k < 257; k++) begin
      step(1, 32'h7000, 0, 0, 0, 0, 0);
      if (k == 255) chk("tag_255", 128'(s_uuid), 128'(255));
      if (k == 256) chk("tag_wrap", 128'(s_uuid), 128'(0));
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
    end

    // Random traffic over a small block pool to force merges, stalls and spurious fills.
    for (int k = 0; k < 3000; k++) begin
      a = 32'hA000 + 32'($urandom_range(0, 5)) * 16 + 32'($urandom_range(0, 3)) * 4;
      fid = int'($urandom_range(0, ENTRIES - 1));
      if ($urandom_range(0, 3) != 0)
        for (int i = 0; i < ENTRIES; i++) if (m_busy[i] && m_issued[i]) fid = i;
      step($urandom_range(0, 9) < 6, a, $urandom_range(0, 1) == 1, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, fid);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
